// File: rtl/sram_like_arbiter.sv
// Merges the core's instruction and data sram-like ports onto one variable-latency
// sram-like memory port, one transaction in flight, with a per-transaction watchdog.
module sram_like_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              bus_err_q;

  logic              accept_data, accept_inst;
  logic              timeout_hit, done_ok, done_to, done;
  logic [DATA_W-1:0] rdata_ret;

  // Acceptance is gated by resetn so no addr_ok escapes while reset is held.
  always_comb begin
    accept_data = resetn && (state_q == S_IDLE) && data_req;
    accept_inst = resetn && (state_q == S_IDLE) && !data_req && inst_req;
    done_ok     = (state_q == S_DATA) && mem_data_ok;
    timeout_hit = (TIMEOUT != 0) && (state_q != S_IDLE) && (cnt_q == CNT_W'(TIMEOUT));
    done_to     = timeout_hit && !done_ok;
    done        = done_ok || done_to;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_data || accept_inst) state_d = S_ADDR;
      S_ADDR: begin
        if (done_to)          state_d = S_IDLE;
        else if (mem_addr_ok) state_d = S_DATA;
      end
      S_DATA: if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_INST;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_data) begin
        owner_q <= OWN_DATA;
        wr_q    <= data_wr;
        wstrb_q <= data_wstrb;
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
      end else if (accept_inst) begin
        owner_q <= OWN_INST;
        wr_q    <= 1'b0;
        wstrb_q <= '0;
        addr_q  <= inst_addr;
        wdata_q <= '0;
      end
      if (accept_data || accept_inst)
        cnt_q <= '0;
      else if ((state_q != S_IDLE) && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
      if (done_to)
        bus_err_q <= 1'b1;
    end
  end

  // Stores and watchdog completions return zero read data.
  always_comb begin
    rdata_ret = '0;
    if (done_ok && !((owner_q == OWN_DATA) && wr_q))
      rdata_ret = mem_rdata;
  end

  always_comb begin
    inst_addr_ok = accept_inst;
    data_addr_ok = accept_data;
    inst_data_ok = done && (owner_q == OWN_INST);
    data_data_ok = done && (owner_q == OWN_DATA);
    inst_rdata   = inst_data_ok ? rdata_ret : '0;
    data_rdata   = data_data_ok ? rdata_ret : '0;
    mem_req      = (state_q == S_ADDR);
    mem_wr       = wr_q;
    mem_wstrb    = wstrb_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    bus_err      = bus_err_q;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: stimulus pushes expected responses and memory
// requests into queues; a monitor and a memory responder pop and compare them.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, bus_err;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_inst; logic [31:0] rdata; } sb_t;
  typedef struct { logic wr; logic [3:0] wstrb; logic [31:0] addr; logic [31:0] wdata; } mx_t;

  sb_t sb[$];
  mx_t mq[$];
  int  checks = 0;
  int  errors = 0;

  int          cfg_addr_delay = 0;
  int          cfg_data_delay = 0;
  logic        cfg_silent = 1'b0;
  logic        cfg_stray_addr = 1'b0;
  logic        cfg_stray_data = 1'b0;
  logic [31:0] cfg_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every *_data_ok.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (inst_data_ok || data_data_ok) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got data_ok inst=%b data=%b, required none", inst_data_ok, data_data_ok);
        end else begin
          e = sb.pop_front();
          chk("sb_both_ok", 32'(inst_data_ok & data_data_ok), 32'd0);
          chk("sb_owner", 32'(inst_data_ok), 32'(e.is_inst));
          chk("sb_rdata", e.is_inst ? inst_rdata : data_rdata, e.rdata);
        end
      end
      if (inst_addr_ok || data_addr_ok)
        chk("addr_ok_excl", 32'(inst_addr_ok & data_addr_ok), 32'd0);
    end
  end

  // Memory responder; also checks request fields against the expected-request queue.
  initial begin
    int   mwait = 0;
    logic mphase = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
      if (!resetn) begin
        mphase = 1'b0; mwait = 0;
      end else if (!mphase && mem_req) begin
        if (mwait >= cfg_addr_delay) mem_addr_ok = 1'b1; else mwait++;
      end else if (mphase && !cfg_silent) begin
        if (mwait >= cfg_data_delay) begin
          mem_data_ok = 1'b1; mem_rdata = cfg_rdata;
        end else mwait++;
      end
      if (cfg_stray_addr) mem_addr_ok = 1'b1;
      if (cfg_stray_data) begin mem_data_ok = 1'b1; mem_rdata = cfg_rdata; end
      @(negedge clk);
      if (mem_req) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got request addr %h, required none", mem_addr);
        end else begin
          chk("mem_wr", 32'(mem_wr), 32'(mq[0].wr));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(mq[0].wstrb));
          chk("mem_addr", mem_addr, mq[0].addr);
          chk("mem_wdata", mem_wdata, mq[0].wdata);
          if (mem_addr_ok) begin
            void'(mq.pop_front());
            mphase = 1'b1; mwait = 0;
          end
        end
      end
      if (inst_data_ok || data_data_ok || !resetn) begin mphase = 1'b0; mwait = 0; end
    end
  end

  task automatic push_exp(input logic is_inst, input logic wr, input logic [3:0] wstrb,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    sb_t s; mx_t m;
    s.is_inst = is_inst; s.rdata = rdata; sb.push_back(s);
    m.wr = wr; m.wstrb = wstrb; m.addr = addr; m.wdata = wdata; mq.push_back(m);
  endtask

  // Called at the start of the cycle after acceptance; counts cycles to the owner's data_ok.
  task automatic wait_done(input logic is_inst, input int exp_lat);
    int lat = 1;
    @(negedge clk);
    chk("mem_req_after_accept", 32'(mem_req), 32'd1);
    while (!(is_inst ? inst_data_ok : data_data_ok) && lat < 40) begin
      @(posedge clk); #1; lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("mem_req_at_done", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic is_inst, input logic wr, input logic [3:0] wstrb,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input int exp_lat);
    if (is_inst) begin
      inst_req = 1'b1; inst_addr = addr;
    end else begin
      data_req = 1'b1; data_wr = wr; data_wstrb = wstrb; data_addr = addr; data_wdata = wdata;
    end
    @(negedge clk);
    chk("accept_ok", 32'(is_inst ? inst_addr_ok : data_addr_ok), 32'd1);
    chk("accept_other", 32'(is_inst ? data_addr_ok : inst_addr_ok), 32'd0);
    chk("accept_mem_req", 32'(mem_req), 32'd0);
    if (is_inst) push_exp(1'b1, 1'b0, 4'h0, addr, 32'h0, exp_rdata);
    else         push_exp(1'b0, wr, wstrb, addr, wdata, exp_rdata);
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
    wait_done(is_inst, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_oks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
    chk("reset_mem", 32'({mem_req, mem_wr, mem_wstrb, bus_err}), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // 1: load, memory latency 1 in each phase
    cfg_rdata = 32'hdeadbeef;
    issue(1'b0, 1'b0, 4'h0, 32'h1c00_0100, 32'h0, 32'hdeadbeef, 2);

    // 2: simultaneous requests, data wins, fetch waits for the first IDLE after data_ok
    cfg_rdata = 32'h1111_2222;
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0000_0200; data_wdata = '0;
    @(negedge clk);
    chk("t2_data_first", 32'(data_addr_ok), 32'd1);
    chk("t2_inst_held", 32'(inst_addr_ok), 32'd0);
    push_exp(1'b0, 1'b0, 4'h0, 32'h0000_0200, 32'h0, 32'h1111_2222);
    @(posedge clk); #1;
    data_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("t2_inst_wait", 32'(inst_addr_ok), 32'd0);
      chk("t2_data_done_cycle", 32'(data_data_ok), (c == 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    cfg_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("t2_inst_after", 32'(inst_addr_ok), 32'd1);
    push_exp(1'b1, 1'b0, 4'h0, 32'h1c00_0004, 32'h0, 32'h3333_4444);
    @(posedge clk); #1;
    inst_req = 1'b0;
    wait_done(1'b1, 2);

    // 3: store held in ADDR for 5 cycles; store returns zero rdata
    cfg_rdata = 32'hcafe_f00d; cfg_addr_delay = 5;
    issue(1'b0, 1'b1, 4'b0011, 32'h0000_0800, 32'h1234_5678, 32'h0, 7);
    cfg_addr_delay = 0;
    // store with no byte enables is forwarded as is
    issue(1'b0, 1'b1, 4'b0000, 32'h0000_0804, 32'ha5a5_a5a5, 32'h0, 2);

    // 6: stray memory handshakes in IDLE are ignored
    cfg_stray_addr = 1'b1; cfg_stray_data = 1'b1; cfg_rdata = 32'hffff_ffff;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_quiet", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req}), 32'd0);
      @(posedge clk); #1;
    end
    cfg_stray_addr = 1'b0; cfg_stray_data = 1'b0;
    cfg_rdata = 32'h0000_0600;
    issue(1'b0, 1'b0, 4'h0, 32'h0000_0600, 32'h0, 32'h0000_0600, 2);

    // memory answers on the exact watchdog cycle: normal completion, no error
    cfg_data_delay = 7; cfg_rdata = 32'h0bad_cafe;
    issue(1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0, 32'h0bad_cafe, 9);
    chk("precedence_bus_err", 32'(bus_err), 32'd0);
    cfg_data_delay = 0;

    // 4: memory never answers; forced completion 8 cycles after entering ADDR
    cfg_silent = 1'b1;
    issue(1'b0, 1'b0, 4'h0, 32'h0000_0400, 32'h0, 32'h0, 9);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    cfg_silent = 1'b0; cfg_rdata = 32'h8c22_0000;
    issue(1'b1, 1'b0, 4'h0, 32'h1c00_0020, 32'h0, 32'h8c22_0000, 2);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);

    // 5: reset while in DATA drops the transaction
    cfg_silent = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0000_0500; data_wdata = '0;
    @(negedge clk);
    chk("t5_accept", 32'(data_addr_ok), 32'd1);
    push_exp(1'b0, 1'b0, 4'h0, 32'h0000_0500, 32'h0, 32'h0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    data_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00_0010;
    @(negedge clk);
    chk("t5_rst_oks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
    chk("t5_rst_mem", 32'({mem_req, mem_wr, mem_wstrb, bus_err}), 32'd0);
    chk("t5_rst_addr", mem_addr, 32'd0);
    chk("t5_rst_wdata", mem_wdata, 32'd0);
    chk("t5_rst_rdata", data_rdata | inst_rdata, 32'd0);
    @(posedge clk); #1;
    inst_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1; cfg_silent = 1'b0; cfg_stray_data = 1'b1; cfg_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("t5_late_data_ok", 32'({inst_data_ok, data_data_ok, mem_req}), 32'd0);
    @(posedge clk); #1;
    cfg_stray_data = 1'b0; cfg_rdata = 32'h2402_0001;
    issue(1'b1, 1'b0, 4'h0, 32'h1c00_0000, 32'h0, 32'h2402_0001, 2);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("mq_drained", 32'(mq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
